// File: rtl/rast_iter_pkg.sv
// Shared types, constants and the subsample step helper for the rasterizer
// sample iterator.
package rast_iter_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef logic signed [SIGFIG-1:0] fix_t;
    typedef fix_t [AXIS-1:0]          vert_t;
    typedef vert_t [VERTS-1:0]        tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;
    typedef fix_t [1:0]               pt_t;   // [0]=x, [1]=y
    typedef pt_t [1:0]                box_t;  // [0]=lower-left, [1]=upper-right

    localparam logic [0:0] WAIT = 1'b0;
    localparam logic [0:0] TEST = 1'b1;

    localparam logic [3:0] SS_8X8 = 4'b0001;
    localparam logic [3:0] SS_4X4 = 4'b0010;
    localparam logic [3:0] SS_2X2 = 4'b0100;
    localparam logic [3:0] SS_1X1 = 4'b1000;

    // Non-one-hot codes fall back to one sample per pixel so the walk still ends.
    function automatic fix_t ss_step(input logic [3:0] ss, input int radix);
        fix_t s;
        case (ss)
            SS_8X8:  s = fix_t'(1) << (radix - 3);
            SS_4X4:  s = fix_t'(1) << (radix - 2);
            SS_2X2:  s = fix_t'(1) << (radix - 1);
            default: s = fix_t'(1) << radix;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bbox_sample_iter_if.sv
// Bounding-box stage to sample-test stage bundle. validTri_R13H is accepted only
// on a cycle where halt_R13L=1; upstream holds its data otherwise.
interface bbox_sample_iter_if;
    import rast_iter_pkg::*;

    tri_t       tri_R13S;
    color_t     color_R13U;
    box_t       box_R13S;
    logic       validTri_R13H;
    logic [3:0] subSample_RnnnnU;
    logic       halt_R13L;
    tri_t       tri_R14S;
    color_t     color_R14U;
    pt_t        sample_R14S;
    logic       validSamp_R14H;
    logic [0:0] state_dbg;

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_R13L, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, state_dbg
    );

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_R13L, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, state_dbg
    );

endinterface

// File: rtl/bbox_sample_iter_adv.sv
// Next raster position within the box and last-sample detection. Sums are one
// bit wider so a box edge near the most positive value cannot wrap.
module bbox_sample_iter_adv
    import rast_iter_pkg::*;
(
    input  fix_t x,
    input  fix_t y,
    input  fix_t ll_x,
    input  fix_t ur_x,
    input  fix_t ur_y,
    input  fix_t step,
    output fix_t next_x,
    output fix_t next_y,
    output logic last
);

    logic signed [SIGFIG:0] sum_x;
    logic signed [SIGFIG:0] sum_y;
    logic signed [SIGFIG:0] ur_x_w;
    logic signed [SIGFIG:0] ur_y_w;

    always_comb begin
        sum_x  = {x[SIGFIG-1], x} + {1'b0, step};
        sum_y  = {y[SIGFIG-1], y} + {1'b0, step};
        ur_x_w = {ur_x[SIGFIG-1], ur_x};
        ur_y_w = {ur_y[SIGFIG-1], ur_y};
        next_x = x;
        next_y = y;
        last   = 1'b0;
        if (sum_x <= ur_x_w) begin
            next_x = sum_x[SIGFIG-1:0];
        end else if (sum_y <= ur_y_w) begin
            next_x = ll_x;
            next_y = sum_y[SIGFIG-1:0];
        end else begin
            last = 1'b1;
        end
    end

endmodule

// File: rtl/bbox_sample_iter.sv
// Walks every subsample position of a triangle's bounding box in raster order,
// one candidate sample per cycle, accepting the next triangle on the last sample.
module bbox_sample_iter
    import rast_iter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    bbox_sample_iter_if.slave bus
);

    logic [0:0] state;
    tri_t       tri_q;
    color_t     color_q;
    fix_t       ll_x;
    fix_t       ur_x;
    fix_t       ur_y;
    fix_t       x;
    fix_t       y;
    logic       valid;
    fix_t       step;
    fix_t       next_x;
    fix_t       next_y;
    logic       last;
    logic       halt;
    logic       load;

    assign step = ss_step(bus.subSample_RnnnnU, RADIX);

    bbox_sample_iter_adv u_adv (
        .x      (x),
        .y      (y),
        .ll_x   (ll_x),
        .ur_x   (ur_x),
        .ur_y   (ur_y),
        .step   (step),
        .next_x (next_x),
        .next_y (next_y),
        .last   (last)
    );

    // halt depends only on registered state, never on validTri_R13H.
    assign halt = (state == WAIT) | ((state == TEST) & last);
    assign load = halt & bus.validTri_R13H;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            ll_x    <= '0;
            ur_x    <= '0;
            ur_y    <= '0;
            x       <= '0;
            y       <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            state   <= TEST;
            tri_q   <= bus.tri_R13S;
            color_q <= bus.color_R13U;
            ll_x    <= bus.box_R13S[0][0];
            ur_x    <= bus.box_R13S[1][0];
            ur_y    <= bus.box_R13S[1][1];
            x       <= bus.box_R13S[0][0];
            y       <= bus.box_R13S[0][1];
            valid   <= 1'b1;
        end else if (state == TEST) begin
            if (last) begin
                state <= WAIT;
                valid <= 1'b0;
            end else begin
                x <= next_x;
                y <= next_y;
            end
        end
    end

    assign bus.halt_R13L      = halt;
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S[0] = x;
    assign bus.sample_R14S[1] = y;
    assign bus.validSamp_R14H = valid;
    assign bus.state_dbg      = state;

    a_ss_one_hot: assert property (@(posedge clk) disable iff (!rst)
        $onehot(bus.subSample_RnnnnU));

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Bench for bbox_sample_iter: table of boxes with hand-computed sample counts,
// plus back-to-back/hold-off and mid-triangle reset sequences.
module tb_bbox_sample_iter;
    import rast_iter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    bbox_sample_iter_if bus ();

    bbox_sample_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ss;
        int step;
        int llx;
        int lly;
        int urx;
        int ury;
        int exp_n;
    } vec_t;

    vec_t vecs[6];
    logic [3*SIGFIG-1:0] exp_q[$];  // {tag, y, x}

    function automatic tri_t mk_tri(input int tag);
        tri_t t;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[v][a] = fix_t'(tag * 16 + v * 4 + a);
        return t;
    endfunction

    function automatic color_t mk_color(input int tag);
        color_t c;
        for (int i = 0; i < COLORS; i++)
            c[i] = SIGFIG'(tag * 3 + i + 7);
        return c;
    endfunction

    function automatic logic [255:0] u24(input logic [23:0] v);
        return {232'd0, v};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_tri(input int tag, input logic [3:0] ss,
                             input int llx, input int lly, input int urx, input int ury);
        bus.tri_R13S         = mk_tri(tag);
        bus.color_R13U       = mk_color(tag);
        bus.box_R13S[0][0]   = fix_t'(llx);
        bus.box_R13S[0][1]   = fix_t'(lly);
        bus.box_R13S[1][0]   = fix_t'(urx);
        bus.box_R13S[1][1]   = fix_t'(ury);
        bus.subSample_RnnnnU = ss;
    endtask

    task automatic build_exp(input int tag, input int step,
                             input int llx, input int lly, input int urx, input int ury);
        for (int yy = lly; yy <= ury; yy += step)
            for (int xx = llx; xx <= urx; xx += step)
                exp_q.push_back({fix_t'(tag), fix_t'(yy), fix_t'(xx)});
    endtask

    // Compares the presented sample with the queue head; halt is expected on a
    // triangle's last sample (queue empty or next entry from another triangle).
    task automatic check_sample(input string name);
        logic [3*SIGFIG-1:0] e;
        logic exp_halt;
        chk({name, " pending"}, {255'd0, exp_q.size() != 0}, 256'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            exp_halt = (exp_q.size() == 0) || (exp_q[0][71:48] != e[71:48]);
            chk({name, " x"}, u24(bus.sample_R14S[0]), u24(e[23:0]));
            chk({name, " y"}, u24(bus.sample_R14S[1]), u24(e[47:24]));
            chk({name, " tri"}, {40'd0, bus.tri_R14S}, {40'd0, mk_tri(int'(e[71:48]))});
            chk({name, " color"}, {184'd0, bus.color_R14U}, {184'd0, mk_color(int'(e[71:48]))});
            chk({name, " halt"}, {255'd0, bus.halt_R13L}, {255'd0, exp_halt});
        end
    endtask

    task automatic finish_stream(input string name);
        chk({name, " valid low"}, {255'd0, bus.validSamp_R14H}, 256'd0);
        chk({name, " halt idle"}, {255'd0, bus.halt_R13L}, 256'd1);
        chk({name, " leftover"}, 256'(exp_q.size()), 256'd0);
    endtask

    task automatic run_stream(input string name, output int n);
        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!bus.validSamp_R14H) break;
            check_sample(name);
            n++;
            @(posedge clk);
            #1;
        end
        finish_stream(name);
    endtask

    initial begin
        int n;
        logic feeding;
        logic acc;

        vecs[0] = '{SS_1X1, 1024, 0, 0, 0, 0, 1};
        vecs[1] = '{SS_1X1, 1024, 1024, 2048, 2048, 2048, 2};
        vecs[2] = '{SS_4X4, 256, 0, 0, 1024, 1024, 25};
        vecs[3] = '{SS_8X8, 128, -256, -128, 0, 0, 6};
        vecs[4] = '{SS_2X2, 512, 512, 0, 1536, 512, 6};
        vecs[5] = '{SS_1X1, 1024, 8386560, 8387584, 8387584, 8387584, 2};

        bus.validTri_R13H = 1'b0;
        drive_tri(0, SS_1X1, 0, 0, 0, 0);

        // Reset state
        #2;
        chk("rst valid", {255'd0, bus.validSamp_R14H}, 256'd0);
        chk("rst halt", {255'd0, bus.halt_R13L}, 256'd1);
        chk("rst sample", {208'd0, bus.sample_R14S}, 256'd0);
        chk("rst tri", {40'd0, bus.tri_R14S}, 256'd0);
        chk("rst color", {184'd0, bus.color_R14U}, 256'd0);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table of single triangles
        foreach (vecs[i]) begin
            drive_tri(i + 1, vecs[i].ss, vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury);
            build_exp(i + 1, vecs[i].step, vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury);
            bus.validTri_R13H = 1'b1;
            @(posedge clk);
            #1;
            bus.validTri_R13H = 1'b0;
            run_stream($sformatf("vec%0d", i), n);
            chk($sformatf("vec%0d count", i), 256'(n), 256'(vecs[i].exp_n));
        end

        // Held valid with changing data: ignored until the last sample, then
        // captured with no bubble between the two triangles.
        drive_tri(50, SS_1X1, 0, 0, 2048, 0);
        build_exp(50, 1024, 0, 0, 2048, 0);
        build_exp(102, 1024, 2048, 4096, 2048, 4096);
        bus.validTri_R13H = 1'b1;
        @(posedge clk);
        #1;
        feeding = 1'b1;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (feeding) drive_tri(100 + k, SS_1X1, 1024 * k, 4096, 1024 * k, 4096);
            @(negedge clk);
            if (!bus.validSamp_R14H) break;
            check_sample("b2b");
            n++;
            acc = feeding && bus.halt_R13L;
            @(posedge clk);
            #1;
            if (acc) begin
                feeding = 1'b0;
                bus.validTri_R13H = 1'b0;
            end
        end
        finish_stream("b2b");
        chk("b2b count", 256'(n), 256'd4);

        // Reset on the third sample of a 25-sample box
        drive_tri(60, SS_4X4, 0, 0, 1024, 1024);
        build_exp(60, 256, 0, 0, 1024, 1024);
        bus.validTri_R13H = 1'b1;
        @(posedge clk);
        #1;
        bus.validTri_R13H = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_sample("pre_rst");
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("mid_rst valid", {255'd0, bus.validSamp_R14H}, 256'd0);
        chk("mid_rst halt", {255'd0, bus.halt_R13L}, 256'd1);
        chk("mid_rst sample", {208'd0, bus.sample_R14S}, 256'd0);
        chk("mid_rst tri", {40'd0, bus.tri_R14S}, 256'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("held_rst valid", {255'd0, bus.validSamp_R14H}, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_tri(61, SS_1X1, 4096, 4096, 5120, 4096);
        build_exp(61, 1024, 4096, 4096, 5120, 4096);
        bus.validTri_R13H = 1'b1;
        @(posedge clk);
        #1;
        bus.validTri_R13H = 1'b0;
        run_stream("post_rst", n);
        chk("post_rst count", 256'(n), 256'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bbox_sample_iter.md
# bbox_sample_iter

Sample iterator stage of the rasterizer, sitting between the bounding-box stage (R13) and the sample-test/hash stage (R14 onward). It accepts one triangle at a time with its subsample-aligned bounding box, then walks every subsample position inside the box in raster order, emitting one candidate sample per cycle. The sample-test and sample-count scoreboards downstream consume this sample stream. Back-pressure to the bounding-box stage is a single active-low halt.

## Interface
- SIGFIG, 24, bits in position/color fixed-point words
- RADIX, 10, fraction bits; one pixel = 1<<RADIX
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels

- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- tri_R13S  input  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle vertices
- color_R13U  input  [SIGFIG-1:0] [COLORS]  triangle color
- box_R13S  input  signed [SIGFIG-1:0] [2][2]  box; [0]=lower-left (x,y), [1]=upper-right (x,y), aligned to subsample grid
- validTri_R13H  input  1  triangle/box valid
- subSample_RnnnnU  input  [3:0]  one-hot: [0]=8x8, [1]=4x4, [2]=2x2, [3]=1x1 per pixel; quasi-static
- halt_R13L  output  1  1 = can accept triangle this cycle; 0 = upstream holds
- tri_R14S  output  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle for current sample
- color_R14U  output  [SIGFIG-1:0] [COLORS]  color for current sample
- sample_R14S  output  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R14H  output  1  sample_R14S valid

## Operation
- Step size: step = 1 << (RADIX − ss_w_lg2), ss_w_lg2 = 3/2/1/0 for subSample bits [0]/[1]/[2]/[3] → 128/256/512/1024. Non-one-hot subSample: undefined, assertion fires.
- FSM states WAIT, TEST.
- WAIT: halt_R13L=1, validSamp_R14H=0. If validTri_R13H: latch tri, color, box; sample ← box lower-left; validSamp ← 1; go TEST.
- TEST: current sample is presented. Advance at each edge:
  - next_x = x + step; if next_x ≤ ur_x: x ← next_x.
  - else if y + step ≤ ur_y: x ← ll_x, y ← y + step.
  - else last sample: if validTri_R13H, load new triangle exactly as in WAIT (stay TEST); else validSamp ← 0, go WAIT.
- halt_R13L = (state==WAIT) | (state==TEST & last); combinational from state and registers only, never from validTri_R13H.
- validTri_R13H while halt_R13L=0: ignored; upstream holds data.
- Sample count per triangle = ((ur_x−ll_x)/step+1)·((ur_y−ll_y)/step+1); ll==ur gives exactly one sample.
- Comparisons signed, SIGFIG+1 bits to avoid overflow at ur near max positive.

## Timing
- Reset (rst=0, async): state WAIT, validSamp_R14H=0, halt_R13L=1, tri/color/sample outputs 0. Reset mid-triangle aborts; no further samples from that triangle.
- Latency: triangle accepted at edge t → first sample valid in cycle after t; one sample per cycle, no bubbles within a triangle.
- Back-to-back: triangle offered during last-sample cycle is accepted; its first sample follows with zero bubble cycles.
- All R14 outputs registered; tri/color stable for every sample of a triangle.

## Structure
- Shared package rast_iter_pkg: state enum (WAIT, TEST), function ss_step(subSample, RADIX) returning step, constant SS_ONE_HOT codes.
- One sub-module natural: bbox_sample_iter_adv (combinational next-x/next-y/last calculation), instantiated once; registers use existing dff/dff2/dff3 with reset.

## Test plan
- 1x1 (subSample=4'b1000), box (0,0)-(0,0) → one sample (0,0); halt_R13L stays 1.
- 1x1, box (1024,2048)-(2048,2048) → samples (1024,2048),(2048,2048) on consecutive cycles, then validSamp=0.
- 4x4 (4'b0010, step 256), box (0,0)-(1024,1024) → 25 samples raster order, x row 0,256,…,1024 per y; row wrap x back to 0.
- Two triangles back-to-back, second held valid from start → second's first sample in cycle right after first's last; no bubble; tri_R14S switches at boundary.
- validTri held during TEST with changing data → ignored until last cycle; data captured exactly then.
- Reset asserted on 3rd sample of 25-sample box → validSamp_R14H=0 immediately, halt_R13L=1; after release, new triangle iterates from its ll.
